// File: rtl/heater_mod_pkg.sv
// heater_mod_pkg: shared FSM type and size defaults for the heater bit modulator.
// HEATER_MANCHESTER_EN selects Manchester bit coding (minimum period 2).
package heater_mod_pkg;
  typedef enum logic [1:0] {IDLE, SEND, COOLDOWN} state_t;
  localparam int DATA_W = 64;
  localparam int LEN_W = 6;
  localparam int PERIOD_W = 32;
  localparam int CNT_W = 32;
`ifdef HEATER_MANCHESTER_EN
  localparam int MIN_PERIOD = 2;
`else
  localparam int MIN_PERIOD = 1;
`endif
  localparam bit MANCH = MIN_PERIOD == 2;
endpackage

// File: rtl/heater_period_timer.sv
// heater_period_timer: loadable down-counter; expire is high while the count is zero.
module heater_period_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);
  logic [W-1:0] count;
  assign expire = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= load ? value : expire ? count : count - W'(1);
endmodule

// File: rtl/heater_bit_modulator.sv
// heater_bit_modulator: serialises a host frame MSB-first into timed heater on/off periods plus cooldown.
// Build with HEATER_MANCHESTER_EN for Manchester-coded bit periods.
module heater_bit_modulator #(
  parameter int DATA_W = heater_mod_pkg::DATA_W,
  parameter int LEN_W = heater_mod_pkg::LEN_W,
  parameter int PERIOD_W = heater_mod_pkg::PERIOD_W,
  parameter int CNT_W = heater_mod_pkg::CNT_W
) (
  input  logic                clk_main_a0,
  input  logic                rst_main_n,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic [DATA_W-1:0]   frame_data,
  input  logic [LEN_W-1:0]    frame_len_m1,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic [PERIOD_W-1:0] cooldown_cycles,
  input  logic                abort,
  output logic                ro_heating_enable,
  output logic                busy,
  output logic [LEN_W-1:0]    bit_index,
  output logic                done_pulse,
  output logic [CNT_W-1:0]    frames_sent
);
  import heater_mod_pkg::*;
  state_t state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [LEN_W-1:0] len_q;
  logic [PERIOD_W-1:0] period_q, cool_q, period_in, load_val;
  logic sec_q, sec_nx, accept, bit_end, half_end, last_bit, finish, tmr_load, tmr_exp, enable_nx;
  assign frame_ready = state == IDLE && !abort;
  assign busy = state != IDLE;
  assign accept = frame_valid && frame_ready;
  assign period_in = bit_period < PERIOD_W'(MIN_PERIOD) ? PERIOD_W'(MIN_PERIOD) : bit_period;
  // sec_q marks the second half of a Manchester bit; it never sets in the plain build
  assign bit_end = state == SEND && tmr_exp && (sec_q || !MANCH);
  assign half_end = state == SEND && tmr_exp && !sec_q && MANCH;
  assign last_bit = bit_index == len_q;
  always_comb begin
    state_nx = state;
    if (busy && abort) state_nx = IDLE;
    else if (accept) state_nx = SEND;
    else if (bit_end && last_bit) state_nx = cool_q != '0 ? COOLDOWN : IDLE;
    else if (state == COOLDOWN && tmr_exp) state_nx = IDLE;
    finish = !abort && ((bit_end && last_bit && cool_q == '0) || (state == COOLDOWN && tmr_exp));
    tmr_load = accept || (state == SEND && tmr_exp);
    load_val = accept ? (MANCH ? period_in >> 1 : period_in) - PERIOD_W'(1) :
               half_end ? period_q - (period_q >> 1) - PERIOD_W'(1) :
               !last_bit ? (MANCH ? period_q >> 1 : period_q) - PERIOD_W'(1) :
               cool_q - PERIOD_W'(1);
    shreg_nx = accept ? frame_data : bit_end ? shreg << 1 : shreg;
    sec_nx = half_end || (sec_q && !bit_end && !accept);
    enable_nx = state_nx == SEND && (shreg_nx[DATA_W-1] ^ sec_nx);
  end
  always_ff @(posedge clk_main_a0 or negedge rst_main_n)
    if (!rst_main_n) begin
      state <= IDLE;
      shreg <= '0;
      len_q <= '0;
      period_q <= '0;
      cool_q <= '0;
      sec_q <= 1'b0;
      ro_heating_enable <= 1'b0;
      bit_index <= '0;
      done_pulse <= 1'b0;
      frames_sent <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      sec_q <= sec_nx;
      ro_heating_enable <= enable_nx;
      bit_index <= state_nx != SEND ? '0 : bit_index + LEN_W'(bit_end);
      done_pulse <= finish;
      frames_sent <= frames_sent + CNT_W'(finish);
      if (accept) begin
        len_q <= frame_len_m1;
        period_q <= period_in;
        cool_q <= cooldown_cycles;
      end
    end
  heater_period_timer #(.W(PERIOD_W)) u_timer (
    .clk(clk_main_a0),
    .rst_n(rst_main_n),
    .load(tmr_load),
    .value(load_val),
    .expire(tmr_exp)
  );
endmodule
